// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clock-enable pixel divider, H/V counters and a
// registered pin stage that keeps colour and sync aligned one pixel behind DrawX/DrawY.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  Pix_R,
    input  logic [7:0]  Pix_G,
    input  logic [7:0]  Pix_B,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        pix_en,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // 11-bit window bounds so a window ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be 1024 or less");
        end
        if (CLK_DIV < 2) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be 2 or greater");
        end
    endgenerate

    logic [DIV_W-1:0] div_q, div_d;
    logic             vclk_q, vclk_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic             fstart_q, fstart_d;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic             blank_n_q, blank_n_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;

    logic        step;
    logic        h_wrap;
    logic        v_wrap;
    logic        visible;
    logic        in_hs;
    logic        in_vs;
    logic [10:0] hx;
    logic [10:0] vy;

    assign step    = (div_q == DIV_LAST);
    assign h_wrap  = (hcnt_q == H_LAST);
    assign v_wrap  = (vcnt_q == V_LAST);
    assign hx      = {1'b0, hcnt_q};
    assign vy      = {1'b0, vcnt_q};
    assign visible = (hx < H_VIS) && (vy < V_VIS);
    assign in_hs   = (hx >= HS_BEG) && (hx < HS_END);
    assign in_vs   = (vy >= VS_BEG) && (vy < VS_END);

    always_comb begin
        div_d     = step ? '0 : div_q + 1'b1;
        vclk_d    = (div_d >= DIV_HALF);
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        fcnt_d    = fcnt_q;
        fstart_d  = 1'b0;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        blank_n_d = blank_n_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        if (step) begin
            hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
            if (h_wrap) begin
                vcnt_d = v_wrap ? 10'd0 : vcnt_q + 10'd1;
                if (v_wrap) begin
                    fcnt_d   = fcnt_q + 16'd1;
                    fstart_d = 1'b1;
                end
            end
            // Pin stage samples the counts being presented now, i.e. before they advance.
            r_d       = visible ? Pix_R : 8'd0;
            g_d       = visible ? Pix_G : 8'd0;
            b_d       = visible ? Pix_B : 8'd0;
            blank_n_d = visible;
            hs_d      = in_hs ? HS_POL : ~HS_POL;
            vs_d      = in_vs ? VS_POL : ~VS_POL;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_q     <= '0;
            vclk_q    <= 1'b0;
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            fcnt_q    <= 16'd0;
            fstart_q  <= 1'b0;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
            blank_n_q <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
        end else begin
            div_q     <= div_d;
            vclk_q    <= vclk_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            fcnt_q    <= fcnt_d;
            fstart_q  <= fstart_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            blank_n_q <= blank_n_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign pix_en      = step;
    assign VGA_CLK     = vclk_q;
    assign DrawX       = hcnt_q;
    assign DrawY       = vcnt_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = fstart_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, divide-by-4 with inverted
// polarities, tiny raster) checked against an arithmetic raster model every cycle.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        int hv; int hf; int hsw; int hb;
        int vv; int vf; int vsw; int vb;
        int d;
        bit hp; bit vp; bit cpix;
    } cfg_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        pe;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        sn;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        fs;
        logic [15:0] fc;
    } out_t;

    typedef struct {
        int   inst;
        int   x;
        int   y;
        logic bn;
        logic hs;
        logic vs;
    } vec_t;

    localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0, 1'b1};
    localparam cfg_t CFG_B = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b1, 1'b1, 1'b0};
    localparam cfg_t CFG_C = '{8, 2, 3, 3, 6, 1, 2, 1, 2, 1'b0, 1'b1, 1'b0};

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] seed = 32'd0;
    longint      k;
    bit          chk_en = 1'b0;
    int          n_total = 0;
    int          n_bad = 0;

    logic [9:0]  dx[3], dy[3];
    logic        pe[3], vclk[3], hs[3], vs[3], bn[3], sn[3], fs[3];
    logic [7:0]  vr[3], vg[3], vb[3];
    logic [15:0] fc[3];
    logic [23:0] pix[3];

    always #5 Clk = ~Clk;

    // Clk edges since reset release; the model is a pure function of this count.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) k <= 0;
        else       k <= k + 1;
    end

    function automatic logic [23:0] pix_fn(cfg_t c, int x, int y, logic [31:0] s);
        logic [7:0] r, g, b;
        if (c.cpix) return 24'hAA550F;
        r = 8'(x * 7 + y * 13 + int'(s[7:0]));
        g = 8'(x ^ (y << 2) ^ int'(s[15:8]));
        b = 8'(x + y * 3 + int'(s[23:16]));
        return {r, g, b};
    endfunction

    function automatic out_t model(cfg_t c, longint kk, logic [31:0] s);
        out_t   o;
        longint n, ft;
        int     ph, ht, vt, px, py;
        bit     vis;
        ht = c.hv + c.hf + c.hsw + c.hb;
        vt = c.vv + c.vf + c.vsw + c.vb;
        ft = longint'(ht) * vt;
        n  = kk / c.d;
        ph = int'(kk % c.d);
        o = '0;
        o.x    = 10'(n % ht);
        o.y    = 10'((n / ht) % vt);
        o.pe   = (ph == c.d - 1);
        o.vclk = (ph >= c.d / 2);
        o.fc   = 16'((n / ft) % 65536);
        o.fs   = (ph == 0) && (n > 0) && (n % ft == 0);
        if (n == 0) begin
            o.hs = ~c.hp;
            o.vs = ~c.vp;
        end else begin
            px  = int'((n - 1) % ht);
            py  = int'(((n - 1) / ht) % vt);
            vis = (px < c.hv) && (py < c.vv);
            o.bn = vis;
            if (vis) {o.r, o.g, o.b} = pix_fn(c, px, py, s);
            o.hs = (px >= c.hv + c.hf && px < c.hv + c.hf + c.hsw) ? c.hp : ~c.hp;
            o.vs = (py >= c.vv + c.vf && py < c.vv + c.vf + c.vsw) ? c.vp : ~c.vp;
        end
        return o;
    endfunction

    function automatic cfg_t cfg_of(int i);
        case (i)
            0:       return CFG_A;
            1:       return CFG_B;
            default: return CFG_C;
        endcase
    endfunction

    function automatic out_t get_out(int i);
        out_t o;
        o.x = dx[i]; o.y = dy[i]; o.pe = pe[i]; o.vclk = vclk[i];
        o.hs = hs[i]; o.vs = vs[i]; o.bn = bn[i]; o.sn = sn[i];
        o.r = vr[i]; o.g = vg[i]; o.b = vb[i]; o.fs = fs[i]; o.fc = fc[i];
        return o;
    endfunction

    // The downstream colour mapper: combinational colour from the coordinates.
    assign pix[0] = pix_fn(CFG_A, int'(dx[0]), int'(dy[0]), seed);
    assign pix[1] = pix_fn(CFG_B, int'(dx[1]), int'(dy[1]), seed);
    assign pix[2] = pix_fn(CFG_C, int'(dx[2]), int'(dy[2]), seed);

    vga_timing_gen u_a (
        .Clk(Clk), .Reset(Reset),
        .Pix_R(pix[0][23:16]), .Pix_G(pix[0][15:8]), .Pix_B(pix[0][7:0]),
        .DrawX(dx[0]), .DrawY(dy[0]), .pix_en(pe[0]), .VGA_CLK(vclk[0]),
        .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bn[0]), .VGA_SYNC_N(sn[0]),
        .VGA_R(vr[0]), .VGA_G(vg[0]), .VGA_B(vb[0]),
        .frame_start(fs[0]), .frame_count(fc[0])
    );

    vga_timing_gen #(.CLK_DIV(4), .HS_POL(1'b1), .VS_POL(1'b1)) u_b (
        .Clk(Clk), .Reset(Reset),
        .Pix_R(pix[1][23:16]), .Pix_G(pix[1][15:8]), .Pix_B(pix[1][7:0]),
        .DrawX(dx[1]), .DrawY(dy[1]), .pix_en(pe[1]), .VGA_CLK(vclk[1]),
        .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bn[1]), .VGA_SYNC_N(sn[1]),
        .VGA_R(vr[1]), .VGA_G(vg[1]), .VGA_B(vb[1]),
        .frame_start(fs[1]), .frame_count(fc[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b1)
    ) u_c (
        .Clk(Clk), .Reset(Reset),
        .Pix_R(pix[2][23:16]), .Pix_G(pix[2][15:8]), .Pix_B(pix[2][7:0]),
        .DrawX(dx[2]), .DrawY(dy[2]), .pix_en(pe[2]), .VGA_CLK(vclk[2]),
        .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_BLANK_N(bn[2]), .VGA_SYNC_N(sn[2]),
        .VGA_R(vr[2]), .VGA_G(vg[2]), .VGA_B(vb[2]),
        .frame_start(fs[2]), .frame_count(fc[2])
    );

    task automatic check_out(string name, out_t got, out_t exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_val(string name, logic [63:0] got, logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic timeout(string name);
        n_total++;
        n_bad++;
        $display("FAIL %s got=timeout exp=event", name);
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++)
                check_out($sformatf("cycle_inst%0d_k%0d", i, k), get_out(i), model(cfg_of(i), k, seed));
        end
    end

    // Reset lands mid-cycle; the pins must already be at reset values before the next edge.
    task automatic do_reset();
        @(posedge Clk);
        #($urandom_range(1, 3));
        Reset = 1'b1;
        seed  = $urandom;
        #1;
        for (int i = 0; i < 3; i++)
            check_out($sformatf("async_reset_inst%0d", i), get_out(i), model(cfg_of(i), 0, seed));
        repeat (2) @(negedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic wait_pe(int i, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge Clk);
            if (pe[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout($sformatf("wait_pix_en_inst%0d", i));
    endtask

    task automatic wait_at(int i, int x, int y, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge Clk);
            if (pe[i] && dx[i] == 10'(x) && dy[i] == 10'(y)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout($sformatf("wait_at_inst%0d_%0d_%0d", i, x, y));
    endtask

    task automatic wait_hs(int i, logic lvl, output longint t);
        t = -1;
        for (int n = 0; n < 8000; n++) begin
            @(negedge Clk);
            if (hs[i] === lvl) begin
                t = k;
                break;
            end
        end
        if (t < 0) timeout($sformatf("wait_hs_inst%0d_lvl%0d", i, lvl));
    endtask

    task automatic hs_timing(int i, bit pol, longint exp_w, longint exp_p);
        longint t0, t1, t2, tx;
        wait_hs(i, ~pol, tx);
        wait_hs(i, pol, t0);
        wait_hs(i, ~pol, t1);
        wait_hs(i, pol, t2);
        if (tx >= 0 && t0 >= 0 && t1 >= 0 && t2 >= 0) begin
            check_val($sformatf("hs_width_inst%0d", i), 64'(t1 - t0), 64'(exp_w));
            check_val($sformatf("line_period_inst%0d", i), 64'(t2 - t0), 64'(exp_p));
        end
    endtask

    vec_t tbl[21];
    logic [1:0] vclk_pat[4];

    initial begin
        bit     ok;
        int     prev;
        logic [9:0] y0;
        logic [23:0] exp_rgb;

        tbl[0]  = '{0, 0,   0, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{0, 639, 0, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{0, 640, 0, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{0, 655, 0, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{0, 656, 0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{0, 751, 0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{0, 752, 0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{0, 799, 0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{0, 0,   1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{0, 639, 1, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{0, 700, 1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{2, 7,  5, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{2, 8,  5, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{2, 10, 5, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{2, 12, 5, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{2, 13, 5, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{2, 0,  6, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{2, 0,  7, 1'b0, 1'b1, 1'b1};
        tbl[18] = '{2, 11, 8, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{2, 15, 8, 1'b0, 1'b1, 1'b1};
        tbl[20] = '{2, 0,  9, 1'b0, 1'b1, 1'b0};
        vclk_pat[0] = 2'b00;
        vclk_pat[1] = 2'b00;
        vclk_pat[2] = 2'b10;
        vclk_pat[3] = 2'b11;

        Reset = 1'b1;
        seed  = $urandom;
        repeat (3) @(negedge Clk);
        #1 Reset = 1'b0;
        chk_en = 1'b1;

        // DrawX steps 0,1,2 on the first pixel enables after release
        for (int i = 0; i < 3; i++) begin
            wait_pe(0, ok);
            if (ok) check_val($sformatf("start_x%0d", i), 64'(dx[0]), 64'(i));
        end

        prev = -1;
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].inst != prev) do_reset();
            prev = tbl[i].inst;
            wait_at(tbl[i].inst, tbl[i].x, tbl[i].y, ok);
            if (ok) begin
                @(negedge Clk);
                exp_rgb = tbl[i].bn ? pix_fn(cfg_of(tbl[i].inst), tbl[i].x, tbl[i].y, seed) : 24'd0;
                check_val($sformatf("vec%0d_inst%0d_%0d_%0d", i, tbl[i].inst, tbl[i].x, tbl[i].y),
                          64'({vr[tbl[i].inst], vg[tbl[i].inst], vb[tbl[i].inst],
                               bn[tbl[i].inst], hs[tbl[i].inst], vs[tbl[i].inst]}),
                          64'({exp_rgb, tbl[i].bn, tbl[i].hs, tbl[i].vs}));
            end
        end
        // One more table-style point: wrapping into the next frame shows visible colour again.
        wait_at(2, 0, 0, ok);
        if (ok) begin
            @(negedge Clk);
            check_val("vec_c_next_frame", 64'({vr[2], vg[2], vb[2], bn[2], hs[2], vs[2]}),
                      64'({pix_fn(CFG_C, 0, 0, seed), 1'b1, 1'b1, 1'b0}));
        end

        hs_timing(0, 1'b0, 192, 1600);
        hs_timing(1, 1'b1, 384, 3200);

        // DrawX wraps 799 -> 0 with DrawY advancing
        wait_at(0, 799, int'(dy[0]), ok);
        if (ok) begin
            y0 = dy[0];
            @(negedge Clk);
            check_val("x_wrap", 64'({dx[0], dy[0]}), 64'({10'd0, 10'(y0 + 10'd1)}));
        end

        // Divide-by-4 VGA_CLK / pix_en phase pattern
        wait_pe(1, ok);
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge Clk);
                check_val($sformatf("vclk_phase%0d", i), 64'({vclk[1], pe[1]}), 64'(vclk_pat[i]));
            end
        end

        // Frame wrap on the tiny raster: 160 pixel steps per frame at 2 Clk each
        do_reset();
        for (int f = 1; f <= 2; f++) begin
            ok = 1'b0;
            for (int n = 0; n < 2000; n++) begin
                @(negedge Clk);
                if (fs[2]) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) timeout($sformatf("frame_start%0d", f));
            else begin
                check_val($sformatf("frame%0d_k", f), 64'(k), 64'(320 * f));
                check_val($sformatf("frame%0d_pos", f), 64'({dx[2], dy[2], fc[2]}),
                          64'({10'd0, 10'd0, 16'(f)}));
                @(negedge Clk);
                check_val($sformatf("frame%0d_pulse_width", f), 64'(fs[2]), 64'(0));
            end
        end

        // Random run lengths with asynchronous resets landing anywhere in the raster
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(100, 3000)) @(negedge Clk);
            do_reset();
        end
        repeat (400) @(negedge Clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Producer end of the pixel-coordinate interface: generates DrawX/DrawY for the downstream color mapper and consumes the RGB that the mapper returns combinationally.
- Registers that RGB together with HS/VS/BLANK so colour and sync reach the VGA DAC pins aligned.
- Derives the pixel rate from the system clock with a clock-enable divider; no second clock domain.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, Clk cycles per pixel; legal values are 2 or greater
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Pix_R, Pix_G, Pix_B  in  8 each  colour from the mapper for the current DrawX/DrawY
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- pix_en  out  1  one-Clk pulse per pixel step
- VGA_CLK  out  1  pixel clock to DAC
- VGA_HS, VGA_VS  out  1 each  sync outputs
- VGA_BLANK_N  out  1  low outside the visible area
- VGA_SYNC_N  out  1  tied 0
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour
- frame_start  out  1  one-Clk pulse at frame wrap
- frame_count  out  16  frames since reset, wraps

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
- Elaboration rule: H_TOTAL and V_TOTAL must each be 1024 or less.
- Reset value of every output:
  - div, hcnt, vcnt, DrawX, DrawY, pix_en, frame_start, frame_count all = 0
  - VGA_R/G/B = 0, VGA_BLANK_N = 0, VGA_CLK = 0
  - VGA_HS = ~HS_POL and VGA_VS = ~VS_POL (deasserted)
  - Reset mid-frame takes effect immediately (asynchronous); counting restarts at (0,0) on the first Clk edge after release.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div == CLK_DIV-1), combinational from registered div.
  - VGA_CLK is registered and equals 1 while div >= CLK_DIV/2. DAC rising edge therefore falls mid-pixel, with outputs stable.
- Counters, advanced only on Clk edges where pix_en = 1:
  - hcnt increments; when hcnt = H_TOTAL-1 it wraps to 0 and vcnt increments.
  - When vcnt = V_TOTAL-1 and hcnt wraps, vcnt wraps to 0, frame_count increments (65535 -> 0), and frame_start = 1 for exactly one Clk.
- DrawX = hcnt and DrawY = vcnt, driven straight from registers. The mapper's Pix_* is valid by the next pix_en edge.
- Output stage, registered on pix_en edges and sampling the pre-advance counts:
  - visible = (hcnt < H_VISIBLE) and (vcnt < V_VISIBLE)
  - VGA_R/G/B = Pix_* if visible, else 0
  - VGA_BLANK_N = visible
  - VGA_HS = HS_POL when H_VISIBLE+H_FRONT <= hcnt < H_VISIBLE+H_FRONT+H_SYNC, else ~HS_POL
  - VGA_VS = VS_POL when V_VISIBLE+V_FRONT <= vcnt < V_VISIBLE+V_FRONT+V_SYNC, else ~VS_POL
- Latency: pins show the pixel at coordinate (x,y) exactly one pixel step (CLK_DIV Clk) after DrawX/DrawY presented (x,y). Sync and colour share this one-step delay, so they are mutually aligned.
- Between pix_en edges, all outputs except div/VGA_CLK/pix_en/frame_start hold their values.

Test Plan:
- Reset: assert Reset mid-line -> all outputs at reset values within the same cycle; VGA_HS = VGA_VS = 1 (defaults); after release, DrawX = 0, 1, 2 on successive pix_en.
- Line timing (defaults): VGA_HS goes low on the pix_en edge after DrawX = 656 and stays low 96 pixel steps (192 Clk); line period = 1600 Clk; DrawX wraps 799 -> 0 with DrawY += 1.
- Alignment/blank: drive Pix_R = 8'hAA, Pix_G = 8'h55, Pix_B = 8'h0F.
  - At DrawX = 639, DrawY = 0 -> next step VGA_R = AA, VGA_G = 55, VGA_B = 0F, BLANK_N = 1.
  - At DrawX = 640 -> next step RGB = 0, BLANK_N = 0.
  - At DrawY = 480 -> RGB = 0 for the whole line.
- Frame wrap: run 420000 pixel steps -> frame_start pulses exactly once (one Clk) as counts go from (799,524) to (0,0); frame_count 0 -> 1; VGA_VS low during lines 490-491 only.
- Polarity: HS_POL = 1, VS_POL = 1 -> both syncs idle 0 after reset, assert 1 for the same windows.
- Divider: CLK_DIV = 4 -> pix_en every 4th Clk; VGA_CLK pattern 0,0,1,1; line period = 3200 Clk.
